// File: rtl/iiitb_vm_ctrl.sv
// Coin-acceptor arbiter and actuator handshake front-end for the vending-machine core.
// Optional coin_total counter is built when VM_CTRL_COIN_COUNT_EN is defined.
module iiitb_vm_ctrl #(
   parameter int NUM_SLOTS = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_SLOTS-1:0]   coin_req,
   input  logic [2*NUM_SLOTS-1:0] coin_val,
   output logic [NUM_SLOTS-1:0]   coin_ack,
   output logic [1:0]             vm_in,
   input  logic                   vm_out,
   input  logic [1:0]             vm_change,
   output logic                   disp_req,
   input  logic                   disp_ack,
   output logic                   chg_req,
   output logic [1:0]             chg_amt,
   input  logic                   chg_ack,
   output logic                   busy,
   output logic                   coin_err,
   output logic                   fault
`ifdef VM_CTRL_COIN_COUNT_EN
   ,
   output logic [15:0]            coin_total
`endif
);

   localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_OBSERVE,
      S_SERVICE
   } state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [NUM_SLOTS-1:0] coin_ack_q, coin_ack_d;
   logic [1:0]           vm_in_q, vm_in_d;
   logic                 disp_req_q, disp_req_d;
   logic                 chg_req_q, chg_req_d;
   logic [1:0]           chg_amt_q, chg_amt_d;
   logic                 busy_q, busy_d;
   logic                 coin_err_q, coin_err_d;
   logic                 fault_q, fault_d;

   logic [1:0]           slot_code [NUM_SLOTS];
   logic                 grant_found;
   logic [PTR_W-1:0]     grant_idx, cand_idx;
   int                   cand;
   logic [1:0]           grant_code;
   logic                 code_valid;
   logic                 core_active;
   logic [16:0]          cnt_inc;
   logic                 disp_rem, chg_rem;
   logic                 timeout_hit;

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_code
      assign slot_code[gi] = coin_val[2*gi +: 2];
   end

   // Round-robin search starts one past the last granted slot and wraps.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = ptr_q;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 1; k <= NUM_SLOTS; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_SLOTS) cand = cand - NUM_SLOTS;
         cand_idx = PTR_W'(cand);
         if (!grant_found && coin_req[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   assign grant_code  = slot_code[grant_idx];
   assign code_valid  = (grant_code == 2'b01) || (grant_code == 2'b10);
   assign core_active = vm_out || (vm_change != 2'b00);
   assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
   assign disp_rem    = disp_req_q && !disp_ack;
   assign chg_rem     = chg_req_q && !chg_ack;
   // An ack landing on the final allowed cycle still counts as a completed handshake.
   assign timeout_hit = (disp_rem || chg_rem) && (cnt_inc == 17'(TIMEOUT));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (core_active)      state_d = S_SERVICE;
            else if (grant_found) state_d = S_FEED;
         end
         S_FEED:    state_d = (vm_in_q != 2'b00) ? S_OBSERVE : S_IDLE;
         S_OBSERVE: state_d = core_active ? S_SERVICE : S_IDLE;
         S_SERVICE: begin
            if (!(disp_req_q || chg_req_q) || timeout_hit) state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      coin_ack_d = '0;
      vm_in_d    = 2'b00;
      coin_err_d = 1'b0;
      fault_d    = 1'b0;
      disp_req_d = disp_req_q;
      chg_req_d  = chg_req_q;
      chg_amt_d  = chg_amt_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      unique case (state_q)
         S_IDLE, S_OBSERVE: begin
            if (core_active) begin
               disp_req_d = vm_out;
               chg_req_d  = (vm_change != 2'b00);
               chg_amt_d  = vm_change;
               cnt_d      = '0;
            end else if (state_q == S_IDLE && grant_found) begin
               coin_ack_d[grant_idx] = 1'b1;
               vm_in_d    = code_valid ? grant_code : 2'b00;
               coin_err_d = !code_valid;
               ptr_d      = grant_idx;
            end
         end
         S_SERVICE: begin
            cnt_d = cnt_inc[15:0];
            if (timeout_hit) begin
               disp_req_d = 1'b0;
               chg_req_d  = 1'b0;
               fault_d    = 1'b1;
            end else begin
               disp_req_d = disp_rem;
               chg_req_d  = chg_rem;
            end
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= PTR_W'(NUM_SLOTS - 1);
         cnt_q      <= '0;
         coin_ack_q <= '0;
         vm_in_q    <= 2'b00;
         disp_req_q <= 1'b0;
         chg_req_q  <= 1'b0;
         chg_amt_q  <= 2'b00;
         busy_q     <= 1'b0;
         coin_err_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         coin_ack_q <= coin_ack_d;
         vm_in_q    <= vm_in_d;
         disp_req_q <= disp_req_d;
         chg_req_q  <= chg_req_d;
         chg_amt_q  <= chg_amt_d;
         busy_q     <= busy_d;
         coin_err_q <= coin_err_d;
         fault_q    <= fault_d;
      end
   end

   assign coin_ack = coin_ack_q;
   assign vm_in    = vm_in_q;
   assign disp_req = disp_req_q;
   assign chg_req  = chg_req_q;
   assign chg_amt  = chg_amt_q;
   assign busy     = busy_q;
   assign coin_err = coin_err_q;
   assign fault    = fault_q;

`ifdef VM_CTRL_COIN_COUNT_EN
   logic [15:0] total_q, total_d;
   logic [16:0] total_sum;

   // vm_in_q holds the accepted code throughout FEED, so it doubles as the credit source.
   assign total_sum = {1'b0, total_q} + ((vm_in_q == 2'b10) ? 17'd2 : 17'd1);

   always_comb begin
      total_d = total_q;
      if (state_q == S_FEED && vm_in_q != 2'b00) begin
         total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) total_q <= '0;
      else        total_q <= total_d;
   end

   assign coin_total = total_q;
`endif

endmodule
